mbr_store_align: RTL
====================

Name: mbr_store_align

Overview:
Store-side counterpart of the load sign-extension path. It takes a store request with a register value, byte address and size code, and shifts the data into the correct byte lanes. It generates per-byte write enables and drives one or two word-aligned write beats to data memory with an ack handshake. A store that crosses a word boundary is split into two beats. The block sits between the execute stage and the data-memory write port.

Parameters:
ALLOW_MISALIGNED, 1, 1 = split word-crossing stores into two beats; 0 = reject them with err, no memory write.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  store request present
req_ready  output  1  block idle, request accepted when req_valid && req_ready
addr  input  32  byte address of the store
wdata  input  32  register data, right-justified
size  input  3  0/1 = byte, 2/3 = half, 4 = word, 5-7 = illegal (same encoding as the load path)
mem_addr  output  32  word-aligned beat address
mem_wdata  output  32  lane-aligned beat data
mem_be  output  4  byte enables; bit i covers mem_wdata[8i+7:8i]
mem_we  output  1  write beat valid, held until acked
mem_ack  input  1  memory accepted the current beat
done  output  1  one-cycle pulse: store completed
err  output  1  one-cycle pulse: request rejected (illegal size, or misaligned with ALLOW_MISALIGNED=0)
split  output  1  high with done when the store used two beats

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE; req_ready=1; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0; done=0; err=0; split=0.
- Reset mid-operation aborts the store. mem_we is 0 from the next cycle. A beat already acked is not undone.
- States: IDLE, LO, HI, RESP, ERR.
- IDLE:
  - req_ready=1.
  - On accept, capture the request and compute:
    - o = addr[1:0]
    - n = 1, 2 or 4 bytes
    - d64 = {32'b0, wdata} << (8*o)
    - be8 = ((1<<n)-1) << o, with only n bits of wdata used (upper bits masked).
    - needhi = (be8[7:4] != 0).
  - Next state:
    - illegal size -> ERR
    - needhi && !ALLOW_MISALIGNED -> ERR
    - otherwise -> LO
- LO:
  - req_ready=0; mem_we=1; mem_addr={addr[31:2],2'b00}; mem_wdata=d64[31:0]; mem_be=be8[3:0].
  - Outputs are stable while waiting.
  - On mem_ack: -> HI if needhi, else -> RESP.
- HI:
  - mem_we=1; mem_addr={addr[31:2],2'b00}+4, wrapping modulo 2^32; mem_wdata=d64[63:32]; mem_be=be8[7:4].
  - On mem_ack: -> RESP.
- RESP: done=1, split=needhi for one cycle; -> IDLE.
- ERR: err=1 for one cycle, no memory write; -> IDLE.
- Outside LO and HI: mem_we=0 and mem_be=0; mem_ack is ignored.
- Latency, request accepted at cycle T:
  - mem_we rises at T+1.
  - An ack in the same cycle completes that beat (zero-wait memory).
  - Single beat acked at T+1: done at T+2, req_ready=1 at T+3.
  - Two beats with zero wait: done at T+3.
  - Illegal or rejected request: err at T+1, req_ready=1 at T+2.
- No new request is accepted until the block returns to IDLE.
- Misaligned stores that stay within one word (e.g. half at o=1) are single beat, not split.

Test Plan:
- Byte store, addr=0x103, wdata=0xAABBCCDD, size=0, ack immediate -> one beat: mem_addr=0x100, mem_be=4'b1000, mem_wdata[31:24]=0xDD; done at T+2, split=0.
- Half store, addr=0x202, wdata=0x1234ABCD, size=2, ack after 3 wait cycles -> mem_we held with stable outputs: mem_addr=0x200, mem_be=4'b1100, mem_wdata[31:16]=0xABCD; done one cycle after ack.
- Word store, addr=0x301, wdata=0x11223344, size=4, ALLOW_MISALIGNED=1 -> beat 1: mem_addr=0x300, mem_be=1110, data 0x223344xx; beat 2: mem_addr=0x304, mem_be=0001, data[7:0]=0x11; done with split=1.
- Half store, addr=0xFFFFFFFF, size=2 -> beat 2 mem_addr=0x00000000, mem_be=0001; with ALLOW_MISALIGNED=0 -> err pulse at T+1, mem_we never asserted.
- size=5 -> err pulse, no write; size=1 and size=3 behave identically to 0 and 2.
- rst asserted while waiting in HI -> next cycle mem_we=0, req_ready=1, no done; a following word store to 0x400 completes normally with mem_be=1111.

Source files
------------

// File: rtl/mbr_store_align.sv
// Store alignment unit: lane-shifts register data by byte offset, builds byte enables,
// and issues one or two word-aligned write beats to data memory with an ack handshake.
module mbr_store_align #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        done,
  output logic        err,
  output logic        split
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t      state_r;
  logic [63:0] d64_r;
  logic [7:0]  be8_r;
  logic        needhi_r;
  logic [29:0] word_r;

  logic [3:0]  nmask_s;
  logic        illegal_s;
  logic [31:0] data_m_s;
  logic [63:0] d64_s;
  logic [7:0]  be8_s;
  logic        needhi_s;

  // Decode size into a byte-count mask, then shift data and enables into lane position
  always_comb begin
    nmask_s   = 4'b0000;
    illegal_s = 1'b0;
    case (size)
      3'd0, 3'd1: nmask_s = 4'b0001;
      3'd2, 3'd3: nmask_s = 4'b0011;
      3'd4:       nmask_s = 4'b1111;
      default:    illegal_s = 1'b1;
    endcase
    data_m_s = wdata & {{8{nmask_s[3]}}, {8{nmask_s[2]}}, {8{nmask_s[1]}}, {8{nmask_s[0]}}};
    d64_s    = {32'd0, data_m_s} << {addr[1:0], 3'b000};
    be8_s    = {4'd0, nmask_s} << addr[1:0];
    needhi_s = (be8_s[7:4] != 4'd0);
  end

  // Single FSM with all outputs registered on state transitions
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      req_ready <= 1'b1;
      mem_we    <= 1'b0;
      mem_be    <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      split     <= 1'b0;
      d64_r     <= 64'd0;
      be8_r     <= 8'd0;
      needhi_r  <= 1'b0;
      word_r    <= 30'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          split <= 1'b0;
          if (req_valid) begin
            req_ready <= 1'b0;
            d64_r     <= d64_s;
            be8_r     <= be8_s;
            needhi_r  <= needhi_s;
            word_r    <= addr[31:2];
            if (illegal_s || (needhi_s && !ALLOW_MISALIGNED)) begin
              state_r <= ERR;
              err     <= 1'b1;
            end else begin
              state_r   <= LO;
              mem_we    <= 1'b1;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= d64_s[31:0];
              mem_be    <= be8_s[3:0];
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        LO: begin
          if (mem_ack) begin
            if (needhi_r) begin
              state_r   <= HI;
              mem_addr  <= {word_r + 30'd1, 2'b00};
              mem_wdata <= d64_r[63:32];
              mem_be    <= be8_r[7:4];
            end else begin
              state_r <= RESP;
              mem_we  <= 1'b0;
              mem_be  <= 4'd0;
              done    <= 1'b1;
              split   <= 1'b0;
            end
          end else begin
            state_r <= LO;
          end
        end
        HI: begin
          if (mem_ack) begin
            state_r <= RESP;
            mem_we  <= 1'b0;
            mem_be  <= 4'd0;
            done    <= 1'b1;
            split   <= 1'b1;
          end else begin
            state_r <= HI;
          end
        end
        RESP: begin
          state_r   <= IDLE;
          done      <= 1'b0;
          split     <= 1'b0;
          req_ready <= 1'b1;
        end
        ERR: begin
          state_r   <= IDLE;
          err       <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
          mem_we    <= 1'b0;
          mem_be    <= 4'd0;
          done      <= 1'b0;
          err       <= 1'b0;
          split     <= 1'b0;
        end
      endcase
    end
  end

endmodule
